// File: rtl/csa_resolver_if.sv
// Handshake bundle for the carry-save resolver: operand pair in, resolved word out.
interface csa_resolver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cout;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_cout
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_cout
    );
endinterface

// File: rtl/csa_resolver.sv
// Sequential carry-propagate adder: folds a sum/carry row pair into one binary
// word, resolving CHUNK bits per cycle with a running inter-slice carry.
module csa_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst,
    csa_resolver_if.slave  bus
);
    localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("csa_resolver: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                     r_state;
    logic [NCH-1:0][CHUNK-1:0]  r_sum;
    logic [NCH-1:0][CHUNK-1:0]  r_carry;
    logic [NCH-1:0][CHUNK-1:0]  r_res;
    logic [KW-1:0]              r_k;
    logic                       r_c;
    logic                       r_cout;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [CHUNK:0]             w_slice;

    // One CHUNK-wide slice plus the carry rippling in from the slice below.
    assign w_slice = {1'b0, r_sum[r_k]} + {1'b0, r_carry[r_k]} + {{CHUNK{1'b0}}, r_c};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_res;
    assign bus.out_cout  = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_carry     <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_c         <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_sum      <= bus.in_sum;
                        r_carry    <= bus.in_carry;
                        r_k        <= '0;
                        r_c        <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_res[r_k] <= w_slice[CHUNK-1:0];
                    r_c        <= w_slice[CHUNK];
                    if (r_k == KW'(NCH - 1)) begin
                        r_cout      <= w_slice[CHUNK];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    // Result held until taken; IDLE then reopens the input for one cycle minimum.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver that converts a two-row carry-save operand (sum row, carry row) back into a single binary word. It sits at the output of the counter/compressor tree: compressor stages reduce many bit columns into redundant form, and this block performs the final addition. It processes the word in CHUNK-bit slices, one slice per cycle. Input and output use valid/ready handshakes.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK; violation is an elaboration-time error.
- CHUNK, 8: bits resolved per cycle. NCH = WIDTH/CHUNK slices.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  sum row; bit i has weight 2^i.
- in_carry  input  WIDTH  carry row, pre-aligned; bit i has weight 2^i.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1, out_valid=0. An accept (in_valid & in_ready at a posedge) does the following:
  - latch in_sum and in_carry into operand registers;
  - clear the slice index k to 0 and the running carry c to 0;
  - go to ADD.
- ADD: in_ready=0. Each cycle computes {c', r} = sum[k] + carry[k] + c, where slices are CHUNK bits wide.
  - Write r to result slice k. Set c <= c'.
  - If k == NCH-1: set out_cout <= c' and go to DONE. Otherwise set k <= k+1.
- DONE: out_valid=1, in_ready=0. out_data and out_cout are held stable.
  - On out_valid & out_ready: go to IDLE.
- in_valid while the block is not in IDLE is ignored. The operand registers are not disturbed, and the upstream must hold its data until in_ready.
- Arithmetic is unsigned, modulo 2^WIDTH. Overflow is reported only through out_cout and is never saturated.
- Input data is not used after the accept cycle. in_sum and in_carry may change freely during ADD and DONE.
- Degenerate case CHUNK == WIDTH (NCH = 1) is legal: ADD lasts exactly one cycle.

## Timing
- Reset values, effective on the first posedge with rst=1:
  - state = IDLE; in_ready = 0 while rst is high, then 1 in the first cycle after rst falls;
  - out_valid = 0, out_data = 0, out_cout = 0;
  - k = 0, c = 0; operand registers = 0.
- Reset mid-operation, in ADD or DONE: the operation is aborted, any pending result is dropped, and all outputs take their reset values. No partial out_valid pulse is produced.
- Latency: accept at posedge t. out_valid rises after posedge t+NCH, i.e. it is visible in the cycle following that edge.
- Throughput: at most one result per NCH+2 cycles. This assumes out_ready=1 when out_valid rises: DONE lasts one cycle, then IDLE lasts one cycle before the next accept.
- All outputs are driven from registers or directly decoded from state. There are no combinational paths from in_* or out_ready to any output.
- Backpressure: DONE persists indefinitely while out_ready=0. out_data and out_cout must not change during this time.
- out_ready asserted while out_valid=0 has no effect.

## Test plan
- Reset then idle (WIDTH=32, CHUNK=8): assert rst for 2 cycles, then release.
  - Required: out_valid=0, out_data=0, out_cout=0, and in_ready=1 from the first cycle after release.
- Full carry ripple: in_sum=0xFFFFFFFF, in_carry=0x00000001, out_ready=1.
  - Required: out_data=0x00000000, out_cout=1, out_valid high 4 cycles after the accept edge, for exactly 1 cycle.
- Ordinary add with a carry crossing a slice boundary: in_sum=0x12345678, in_carry=0x0000FF88.
  - Required: out_data=0x12355600, out_cout=0.
- Backpressure and busy input:
  - Stimulus: accept 0x80000000+0x80000000, hold out_ready=0 for 10 cycles, and drive in_valid=1 with different data throughout.
  - Required: in_ready=0 the whole time; out_data=0x00000000 and out_cout=1 stable; the second operand is accepted only after the output handshake plus one IDLE cycle.
- Reset mid-ADD: assert rst at slice k=2 of an operation.
  - Required: out_valid never pulses and outputs return to their reset values.
  - A following operation 0x00000001+0x00000001 returns 0x00000002, showing no stale carry or slice state remains.
- Randomized back-to-back traffic:
  - Stimulus: 1000 random pairs with random in_valid/out_ready gaps, in two configurations: CHUNK=8, and CHUNK=32 (NCH=1).
  - Required: every result equals the reference sum and carry, in order, with no drops or duplicates.
